// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side bundle for the shared 4:1 bit path: request/data in,
// grant/select/busy and the selected bit out.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] I;
    logic [3:0] gnt;
    logic [1:0] S;
    logic       busy;
    logic       Y;

    modport master (output req, output I, input gnt, input S, input busy, input Y);
    modport slave  (input req, input I, output gnt, output S, output busy, output Y);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner selection for a single shared 4:1 one-bit mux, with a
// hold limit that forces rotation when the owner has a waiting contender.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no grant; S keeps the last owner, Y forced low
// ST_GRANT | requester last_q owns the path; cnt_q counts hold cycles
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 4
) (
    input logic                clk,
    input logic                rst,
    mux4_rr_arbiter_if.slave   bus
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    logic          state_q, state_d;
    logic [1:0]    last_q,  last_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [3:0]    gnt_q,   gnt_d;
    logic [1:0]    s_q,     s_d;
    logic          busy_q,  busy_d;

    logic [3:0]    others;
    logic          any_other;
    logic [1:0]    win_idle;
    logic [1:0]    win_ho;

    // First set bit of r at or after last+1; last itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign others    = bus.req & ~(4'b0001 << last_q);
    assign any_other = |others;
    assign win_idle  = rr_pick(bus.req, last_q);
    assign win_ho    = rr_pick(others, last_q);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d = ST_GRANT;
                    last_d  = win_idle;
                    s_d     = win_idle;
                    gnt_d   = 4'b0001 << win_idle;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (!bus.req[last_q] || (cnt_q == HOLD_LAST && any_other)) begin
                    if (any_other) begin
                        last_d = win_ho;
                        s_d    = win_ho;
                        gnt_d  = 4'b0001 << win_ho;
                        busy_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            s_q     <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.S    = s_q;
    assign bus.busy = busy_q;
    assign bus.Y    = busy_q ? bus.I[s_q] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scenario bench for mux4_rr_arbiter: a default-hold instance and a
// MAX_HOLD=2 instance, expectations queued per cycle and checked after each edge.
module tb_mux4_rr_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] s;
        logic       busy;
        logic       y;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    mux4_rr_arbiter_if a_if ();
    mux4_rr_arbiter_if b_if ();

    mux4_rr_arbiter #(.MAX_HOLD(8), .CW(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    mux4_rr_arbiter #(.MAX_HOLD(2), .CW(4)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] g, input logic [1:0] s, input logic b,
                                input logic y);
        exp_t e;
        e.gnt = g; e.s = s; e.busy = b; e.y = y;
        return e;
    endfunction

    function automatic string show(input exp_t e);
        return $sformatf("gnt=%b S=%0d busy=%b Y=%b", e.gnt, e.s, e.busy, e.y);
    endfunction

    function automatic exp_t got_a();
        return mk(a_if.gnt, a_if.S, a_if.busy, a_if.Y);
    endfunction

    function automatic exp_t got_b();
        return mk(b_if.gnt, b_if.S, b_if.busy, b_if.Y);
    endfunction

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, g;
        rst = 1'b1;
        a_if.req = 4'b1111; a_if.I = 4'b1111;
        b_if.req = 4'b1111; b_if.I = 4'b1111;
        sb_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        edge_wait();
        g = got_a(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_a: got %s expected %s", show(g), show(e));
        end
        g = got_b(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_b: got %s expected %s", show(g), show(e));
        end
        rst = 1'b0;
        a_if.req = 4'b0000; a_if.I = 4'b0000;
        b_if.req = 4'b0000; b_if.I = 4'b0000;
        edge_wait();
    endtask

    // Owner 1 is forced off after 8 held cycles because requester 3 waits.
    task automatic test_forced_rotation();
        exp_t e, g;
        a_if.req = 4'b1010; a_if.I = 4'b0010;
        for (int c = 1; c <= 11; c++) begin
            if (c <= 8) sb_q.push_back(mk(4'b0010, 2'd1, 1'b1, 1'b1));
            else        sb_q.push_back(mk(4'b1000, 2'd3, 1'b1, 1'b0));
            edge_wait();
            g = got_a(); e = sb_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL forced_rotation cyc %0d: got %s expected %s", c, show(g), show(e));
            end
        end
        a_if.req = 4'b0000;
        sb_q.push_back(mk(4'b0000, 2'd3, 1'b0, 1'b0));
        edge_wait();
        g = got_a(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL forced_rotation idle: got %s expected %s", show(g), show(e));
        end
    endtask

    task automatic test_single_hold();
        exp_t e, g;
        a_if.req = 4'b0100; a_if.I = 4'b0100;
        for (int c = 1; c <= 20; c++) begin
            sb_q.push_back(mk(4'b0100, 2'd2, 1'b1, 1'b1));
            edge_wait();
            g = got_a(); e = sb_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL single_hold cyc %0d: got %s expected %s", c, show(g), show(e));
            end
        end
        a_if.req = 4'b0000;
        sb_q.push_back(mk(4'b0000, 2'd2, 1'b0, 1'b0));
        edge_wait();
        g = got_a(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL single_hold release: got %s expected %s", show(g), show(e));
        end
    endtask

    // MAX_HOLD=2 instance: all four requesting rotates 0,1,2,3 two cycles each.
    task automatic test_fairness();
        exp_t e, g;
        logic [3:0] ival;
        int o;
        ival = 4'b0110;
        b_if.req = 4'b1111; b_if.I = ival;
        for (int c = 1; c <= 16; c++) begin
            o = ((c - 1) / 2) % 4;
            sb_q.push_back(mk(4'b0001 << o, 2'(o), 1'b1, ival[o]));
            edge_wait();
            g = got_b(); e = sb_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL fairness cyc %0d: got %s expected %s", c, show(g), show(e));
            end
        end
        b_if.req = 4'b0000;
        sb_q.push_back(mk(4'b0000, 2'd3, 1'b0, 1'b0));
        edge_wait();
        g = got_b(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL fairness idle: got %s expected %s", show(g), show(e));
        end
    endtask

    // Owner 1 releases with 0 pending (wrap handoff), then a short-lived
    // request from 2 that must go unserved.
    task automatic test_release_handoff();
        exp_t e, g;
        logic [3:0] reqs [6];
        exp_t       exps [6];
        reqs[0] = 4'b0010; exps[0] = mk(4'b0010, 2'd1, 1'b1, 1'b0);
        reqs[1] = 4'b0011; exps[1] = mk(4'b0010, 2'd1, 1'b1, 1'b0);
        reqs[2] = 4'b0001; exps[2] = mk(4'b0001, 2'd0, 1'b1, 1'b1);
        reqs[3] = 4'b0101; exps[3] = mk(4'b0001, 2'd0, 1'b1, 1'b1);
        reqs[4] = 4'b0001; exps[4] = mk(4'b0001, 2'd0, 1'b1, 1'b1);
        reqs[5] = 4'b0000; exps[5] = mk(4'b0000, 2'd0, 1'b0, 1'b0);
        a_if.I = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            a_if.req = reqs[c];
            sb_q.push_back(exps[c]);
            edge_wait();
            g = got_a(); e = sb_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL release_handoff step %0d: got %s expected %s", c, show(g), show(e));
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e, g;
        a_if.I = 4'b0101;
        a_if.req = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            sb_q.push_back(mk(4'b0100, 2'd2, 1'b1, 1'b1));
            edge_wait();
            g = got_a(); e = sb_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL mid_reset hold %0d: got %s expected %s", c, show(g), show(e));
            end
        end
        rst = 1'b1; a_if.req = 4'b1111;
        sb_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        edge_wait();
        g = got_a(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL mid_reset rst: got %s expected %s", show(g), show(e));
        end
        rst = 1'b0;
        sb_q.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b1));
        edge_wait();
        g = got_a(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL mid_reset first_grant: got %s expected %s", show(g), show(e));
        end
        a_if.req = 4'b0000;
        sb_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        edge_wait();
        g = got_a(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL mid_reset idle: got %s expected %s", show(g), show(e));
        end
    endtask

    task automatic test_y_tracking();
        exp_t e, g;
        logic [3:0] ival;
        ival = 4'b1000;
        a_if.I = ival; a_if.req = 4'b1000;
        sb_q.push_back(mk(4'b1000, 2'd3, 1'b1, 1'b1));
        edge_wait();
        g = got_a(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL y_tracking grant: got %s expected %s", show(g), show(e));
        end
        for (int c = 1; c <= 16; c++) begin
            ival = {~ival[3], 3'($urandom_range(0, 7))};
            a_if.I = ival;
            #1;
            checks++;
            if (a_if.Y !== ival[3]) begin
                errors++;
                $display("FAIL y_comb cyc %0d: got Y=%b expected %b", c, a_if.Y, ival[3]);
            end
            sb_q.push_back(mk(4'b1000, 2'd3, 1'b1, ival[3]));
            edge_wait();
            g = got_a(); e = sb_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL y_tracking cyc %0d: got %s expected %s", c, show(g), show(e));
            end
        end
        a_if.req = 4'b0000;
        sb_q.push_back(mk(4'b0000, 2'd3, 1'b0, 1'b0));
        edge_wait();
        g = got_a(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL y_tracking idle: got %s expected %s", show(g), show(e));
        end
        for (int c = 1; c <= 4; c++) begin
            a_if.I = 4'($urandom_range(0, 15)) | 4'b1000;
            #1;
            checks++;
            if (a_if.Y !== 1'b0) begin
                errors++;
                $display("FAIL y_idle_low %0d: got Y=%b expected 0", c, a_if.Y);
            end
            edge_wait();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a_if.req = 4'b0000; a_if.I = 4'b0000;
        b_if.req = 4'b0000; b_if.I = 4'b0000;
        #2;
        test_reset();
        test_forced_rotation();
        test_single_hold();
        test_fairness();
        test_release_handoff();
        test_mid_reset();
        test_y_tracking();
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares a single 4:1 one-bit mux path between four requesters.
- Each requester drives one data bit and a request line. The block grants exactly one requester at a time, drives the 2-bit select to match, and outputs the selected bit.
- A hold limit prevents a requester from monopolising the path while others wait.
- Sits between the requesting agents and the shared serial/bit-level consumer downstream.

Parameters:
- MAX_HOLD, 8, max consecutive grant cycles for one owner while another requester is pending; legal range 1..15.
- CW, 4, width of the internal hold counter; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req  input  4  request, one bit per requester (bit n = requester n)
- I  input  4  data bits; I[n] belongs to requester n
- gnt  output  4  one-hot grant, registered; all zero when idle
- S  output  2  registered select = index of current owner; holds last owner when idle
- busy  output  1  registered; high while any grant is active
- Y  output  1  combinational: I[S] when busy, else 0

Behaviour:
- Clock, reset, outputs:
  - One clock, clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
  - Reset values: gnt=4'b0000, S=2'b00, busy=0, Y=0, hold counter=0, state=IDLE, round-robin pointer last=3 (requester 0 has first priority after reset).
- States: IDLE, GRANT.
- Priority search:
  - Scan from index (last+1) mod 4 upward with wrap-around; the first index with req set wins.
  - Excluding the owner means the scan starts at last+1 and skips index last.
- IDLE:
  - If req==0, stay in IDLE.
  - Else at the next edge: enter GRANT, set gnt to the winner (one-hot), S=winner index, busy=1, last=winner, counter=0.
  - Latency: request sampled at edge k, grant visible after edge k (1 cycle).
- GRANT, owner o=last. At each edge, evaluate in priority order:
  1. Release: req[o]==0.
     - If other requests are pending, hand off directly to the next winner (no idle cycle; counter=0).
     - Otherwise go to IDLE: gnt=0, busy=0, S holds o.
  2. Forced rotation: req[o]==1, counter==MAX_HOLD-1, and another request is pending. Hand off to the next winner excluding o; counter=0.
  3. Otherwise stay. counter increments, saturating at MAX_HOLD-1. With no contender, the owner may hold indefinitely.
- Handoff: at the same edge, update gnt, S and last together. busy stays 1.
- Y tracks I combinationally within the same cycle.
- Simultaneous events:
  - Owner drops req in the same cycle a new req arrives: the new req is considered at that edge and handoff occurs.
  - A request deasserted before being granted is simply not served; no latching of requests.
- Reset mid-operation: rst has priority over all transitions and returns every register to its reset value at that edge, regardless of req.
- Invariants: gnt is one-hot or zero; busy == |gnt; when busy, gnt[S]==1.

Test Plan:
1. Reset, then req=4'b1010, I=4'b0010 → one cycle later gnt=4'b0010, S=1, busy=1, Y=1; with req held, grant persists beyond MAX_HOLD cycles because req[3] is excluded? No: req[3] is pending, so after 8 cycles gnt=4'b1000, S=3, Y=I[3]=0.
2. Single requester req=4'b0100 for 20 cycles → gnt=4'b0100 throughout, no rotation, counter saturated; then req=0 → next cycle gnt=0, busy=0, S=2, Y=0.
3. Round-robin fairness: all req=4'b1111 held, MAX_HOLD=2 → grant order 0,1,2,3,0…, each owner exactly 2 cycles, no idle gaps.
4. Release handoff: owner 1 granted, req changes from 4'b0011 to 4'b0001 → next edge gnt=4'b0001 (wrap from last=1 to 0), busy stays 1.
5. Mid-grant reset: owner 2 active, counter=3, assert rst for one cycle with req=4'b1111 → after that edge gnt=0, S=0, busy=0; after rst is released, first grant goes to requester 0.
6. Y tracking: owner 3 granted, toggle I[3] every cycle and I[0..2] randomly → Y equals I[3] in the same cycle; Y=0 whenever busy=0.
